fetch_queue: RTL and testbench

//  Decoupling FIFO between the fetch stage and the decode stage. Fetch pushes
//  {pc, insn, btbHit, btbPredictedPc} per cycle; decode pops when not stalled.

---
 rtl/fetch_queue_pkg.sv | 35 +++
 rtl/fetch_queue_ram.sv | 36 +++
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch -> decode decoupling queue.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (see fetch_queue.sv).
package fetch_queue_pkg;

  localparam int FETCH_QUEUE_XLEN  = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef logic [FETCH_QUEUE_XLEN-1:0] PC;

  // One fetched instruction together with its branch-prediction metadata.
  typedef struct packed {
    PC                           pc;
    logic [FETCH_QUEUE_XLEN-1:0] insn;
    logic                        btbHit;
    PC                           btbPredictedPc;
  } FetchQueueEntry;

  localparam FetchQueueEntry FETCH_QUEUE_ENTRY_ZERO = '0;

  // Bundle the loose fetch-side fields into one storage entry.
  function automatic FetchQueueEntry packEntry(
    input PC                           pc,
    input logic [FETCH_QUEUE_XLEN-1:0] insn,
    input logic                        btbHit,
    input PC                           btbPredictedPc
  );
    FetchQueueEntry e;
    e.pc             = pc;
    e.insn           = insn;
    e.btbHit         = btbHit;
    e.btbPredictedPc = btbPredictedPc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH x FetchQueueEntry, one synchronous
// write port, one asynchronous read port, asynchronously reset to zero.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wrEn,
  input  logic [AW-1:0]  wrAddr,
  input  FetchQueueEntry wrData,
  input  logic [AW-1:0]  rdAddr,
  output FetchQueueEntry rdData
);

  FetchQueueEntry mem_r [DEPTH];

  // Storage array: cleared on reset, written on the rising edge when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= FETCH_QUEUE_ENTRY_ZERO;
      end
    end else if (wrEn) begin
      mem_r[wrAddr] <= wrData;
    end
  end

  // Head entry is read combinationally so decode sees it in the same cycle.
  always_comb begin
    rdData = mem_r[rdAddr];
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch -> decode decoupling FIFO. Entries leave strictly in push order; a
// flush (branch redirect) empties the queue at the next edge.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, an entry
// arriving at an empty queue while decode is ready is forwarded straight to
// deq_* in the same cycle and never written to storage.
// XLEN must match FETCH_QUEUE_XLEN since the storage entry type is shared.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FETCH_QUEUE_DEPTH,
  parameter int XLEN   = FETCH_QUEUE_XLEN,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [XLEN-1:0]  enq_pc,
  input  logic [XLEN-1:0]  enq_insn,
  input  logic             enq_btb_hit,
  input  logic [XLEN-1:0]  enq_pred_pc,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [XLEN-1:0]  deq_pc,
  output logic [XLEN-1:0]  deq_insn,
  output logic             deq_btb_hit,
  output logic [XLEN-1:0]  deq_pred_pc,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] rdPtr_r;
  logic [PTR_W-1:0] wrPtr_r;
  logic [CNT_W-1:0] count_r;

  logic           empty_s;
  logic           full_s;
  logic           push_s;
  logic           pop_s;
  logic           bypass_s;
  logic           wrEn_s;
  logic           rdAdv_s;
  FetchQueueEntry enqEntry_s;
  FetchQueueEntry rdEntry_s;

  // Occupancy flags. enq_ready looks only at registered occupancy, so a pop
  // never opens a slot for a push in the same cycle (no deq_ready->enq_ready path).
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    full_s    = (count_r == CNT_W'(DEPTH));
    enq_ready = ~full_s;
    count     = count_r;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue, redirect-free, both sides ready: forward the entry directly.
  always_comb begin
    bypass_s = empty_s & ~flush & enq_valid & deq_ready;
  end
`else
  // Without the bypass every entry goes through storage.
  always_comb begin
    bypass_s = 1'b0;
  end
`endif

  // Handshakes; a flush kills both sides. A bypassed entry is neither written
  // nor popped from storage, so occupancy stays at zero for it.
  always_comb begin
    push_s  = enq_valid & ~full_s & ~flush;
    pop_s   = deq_valid & deq_ready;
    wrEn_s  = push_s & ~bypass_s;
    rdAdv_s = pop_s & ~bypass_s;
  end

  // Pack the incoming fetch fields for storage.
  always_comb begin
    enqEntry_s = packEntry(enq_pc, enq_insn, enq_btb_hit, enq_pred_pc);
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn_s),
    .wrAddr (wrPtr_r),
    .wrData (enqEntry_s),
    .rdAddr (rdPtr_r),
    .rdData (rdEntry_s)
  );

  // Pointer and occupancy state; flush outranks any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (wrEn_s) begin
        wrPtr_r <= wrPtr_r + PTR_W'(1);
      end
      if (rdAdv_s) begin
        rdPtr_r <= rdPtr_r + PTR_W'(1);
      end
      case ({wrEn_s, rdAdv_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation to decode. deq_valid is forced low during a flush.
  always_comb begin
    deq_valid   = 1'b0;
    deq_pc      = rdEntry_s.pc;
    deq_insn    = rdEntry_s.insn;
    deq_btb_hit = rdEntry_s.btbHit;
    deq_pred_pc = rdEntry_s.btbPredictedPc;
    if (bypass_s) begin
      deq_valid   = 1'b1;
      deq_pc      = enq_pc;
      deq_insn    = enq_insn;
      deq_btb_hit = enq_btb_hit;
      deq_pred_pc = enq_pred_pc;
    end else begin
      deq_valid   = ~empty_s & ~flush;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue (DEPTH=4, XLEN=32).
// Each vector: inputs driven after the falling edge, outputs checked 1ns
// later (pre-rising-edge state), then the rising edge commits the cycle.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [XLEN-1:0]  enq_pc;
  logic [XLEN-1:0]  enq_insn;
  logic             enq_btb_hit;
  logic [XLEN-1:0]  enq_pred_pc;
  logic             deq_valid;
  logic             deq_ready;
  logic [XLEN-1:0]  deq_pc;
  logic [XLEN-1:0]  deq_insn;
  logic             deq_btb_hit;
  logic [XLEN-1:0]  deq_pred_pc;
  logic [CNT_W-1:0] count;

  int testsRun = 0;
  int testsFailed = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_pc      (enq_pc),
    .enq_insn    (enq_insn),
    .enq_btb_hit (enq_btb_hit),
    .enq_pred_pc (enq_pred_pc),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_pc      (deq_pc),
    .deq_insn    (deq_insn),
    .deq_btb_hit (deq_btb_hit),
    .deq_pred_pc (deq_pred_pc),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        enqValid;
    logic [31:0] enqPc;
    logic        deqReady;
    logic        expDeqValid;
    logic [31:0] expDeqPc;
    logic [2:0]  expCount;
    logic        expEnqReady;
  } Vec;

  Vec vecs[$];

  function automatic Vec mk(logic f, logic ev, logic [31:0] pc, logic dr,
                            logic edv, logic [31:0] epc, logic [2:0] ecnt, logic eer);
    Vec v;
    v.flush = f; v.enqValid = ev; v.enqPc = pc; v.deqReady = dr;
    v.expDeqValid = edv; v.expDeqPc = epc; v.expCount = ecnt; v.expEnqReady = eer;
    return v;
  endfunction

  // Side fields are derived from the PC so each entry is self-describing.
  function automatic logic [31:0] insnOf(logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] predOf(logic [31:0] pc);
    return pc + 32'h0000_1000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic f, logic ev, logic [31:0] pc, logic dr);
    flush       = f;
    enq_valid   = ev;
    enq_pc      = pc;
    enq_insn    = insnOf(pc);
    enq_btb_hit = pc[2];
    enq_pred_pc = predOf(pc);
    deq_ready   = dr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Order: three pushes held, then three pops
    vecs.push_back(mk(0, 1, 32'h100, 0, 0, 32'h0,   3'd0, 1));
    vecs.push_back(mk(0, 1, 32'h104, 0, 1, 32'h100, 3'd1, 1));
    vecs.push_back(mk(0, 1, 32'h108, 0, 1, 32'h100, 3'd2, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h100, 3'd3, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h104, 3'd2, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h108, 3'd1, 1));
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   3'd0, 1));
    // Full: fill, hold enq_valid, pop while full must not admit the 5th entry
    vecs.push_back(mk(0, 1, 32'h110, 0, 0, 32'h0,   3'd0, 1));
    vecs.push_back(mk(0, 1, 32'h114, 0, 1, 32'h110, 3'd1, 1));
    vecs.push_back(mk(0, 1, 32'h118, 0, 1, 32'h110, 3'd2, 1));
    vecs.push_back(mk(0, 1, 32'h11C, 0, 1, 32'h110, 3'd3, 1));
    vecs.push_back(mk(0, 1, 32'h120, 0, 1, 32'h110, 3'd4, 0));
    vecs.push_back(mk(0, 1, 32'h120, 1, 1, 32'h110, 3'd4, 0));
    vecs.push_back(mk(0, 1, 32'h120, 0, 1, 32'h114, 3'd3, 1));
    vecs.push_back(mk(0, 0, 32'h0,   0, 1, 32'h114, 3'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h114, 3'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h118, 3'd3, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h11C, 3'd2, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h120, 3'd1, 1));
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   3'd0, 1));
    // Wrap: ten interleaved push/pop pairs
    for (int k = 0; k < 10; k++) begin
`ifdef FETCH_QUEUE_BYPASS_EN
      vecs.push_back(mk(0, 1, 32'h300 + 32'(4 * k), 1, 1, 32'h300 + 32'(4 * k), 3'd0, 1));
`else
      vecs.push_back(mk(0, 1, 32'h300 + 32'(4 * k), 1, (k > 0),
                        32'h300 + 32'(4 * k) - 32'h4, (k > 0) ? 3'd1 : 3'd0, 1));
`endif
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0, 3'd0, 1));
`else
    vecs.push_back(mk(0, 0, 32'h0, 1, 1, 32'h324, 3'd1, 1));
`endif
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 3'd0, 1));
    // Flush: three held, flush with a push, pushed entry must be absent
    vecs.push_back(mk(0, 1, 32'h400, 0, 0, 32'h0,   3'd0, 1));
    vecs.push_back(mk(0, 1, 32'h404, 0, 1, 32'h400, 3'd1, 1));
    vecs.push_back(mk(0, 1, 32'h408, 0, 1, 32'h400, 3'd2, 1));
    vecs.push_back(mk(1, 1, 32'h40C, 0, 0, 32'h0,   3'd3, 1));
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   3'd0, 1));
    vecs.push_back(mk(0, 1, 32'h410, 0, 0, 32'h0,   3'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,   0, 1, 32'h410, 3'd1, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h410, 3'd1, 1));
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   3'd0, 1));
    // Bypass / minimum latency from an empty queue
`ifdef FETCH_QUEUE_BYPASS_EN
    vecs.push_back(mk(0, 1, 32'h200, 1, 1, 32'h200, 3'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 32'h0,   3'd0, 1));
`else
    vecs.push_back(mk(0, 1, 32'h200, 1, 0, 32'h0,   3'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h200, 3'd1, 1));
`endif
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 3'd0, 1));

    // Reset state while rst is held
    #2;
    check("reset_deq_valid", 32'(deq_valid), 32'h0);
    check("reset_count",     32'(count),     32'h0);
    check("reset_enq_ready", 32'(enq_ready), 32'h1);
    check("reset_deq_pc",    deq_pc,         32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].enqValid, vecs[i].enqPc, vecs[i].deqReady);
      #1;
      check($sformatf("v%0d_deq_valid", i), 32'(deq_valid), 32'(vecs[i].expDeqValid));
      check($sformatf("v%0d_count", i),     32'(count),     32'(vecs[i].expCount));
      check($sformatf("v%0d_enq_ready", i), 32'(enq_ready), 32'(vecs[i].expEnqReady));
      if (vecs[i].expDeqValid) begin
        check($sformatf("v%0d_deq_pc", i),   deq_pc,   vecs[i].expDeqPc);
        check($sformatf("v%0d_deq_insn", i), deq_insn, insnOf(vecs[i].expDeqPc));
        check($sformatf("v%0d_deq_btb", i),  32'(deq_btb_hit), 32'(vecs[i].expDeqPc[2]));
        check($sformatf("v%0d_deq_pred", i), deq_pred_pc, predOf(vecs[i].expDeqPc));
      end
    end

    // Reset mid-stream: two entries held, async rst between edges
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h500, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h504, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("pre_rst_count", 32'(count), 32'h2);
    check("pre_rst_deq_pc", deq_pc, 32'h500);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_deq_valid", 32'(deq_valid), 32'h0);
    check("mid_rst_count",     32'(count),     32'h0);
    check("mid_rst_enq_ready", 32'(enq_ready), 32'h1);
    check("mid_rst_deq_pc",    deq_pc,         32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h600, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("post_rst_deq_valid", 32'(deq_valid), 32'h1);
    check("post_rst_deq_pc",    deq_pc,         32'h600);
    check("post_rst_count",     32'(count),     32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
